// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch PC unit.
// Defines the fetch FSM states, default widths and the redirect target priority.
// Pure declarations; no timing or flow-control behaviour of its own.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HALT   = 2'd3
    } state_e;

    // Which source supplies the redirect target this cycle.
    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JUMPR  = 2'd3
    } tgt_sel_e;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_IMM_W  = 16;
    localparam int DEF_TGT_W  = 26;
    localparam int DEF_CNT_W  = 16;

    // Priority: register jump beats absolute jump beats taken branch.
    function automatic tgt_sel_e sel_target(input logic jump_r, input logic jump_abs,
                                            input logic br_taken);
        if (jump_r)        return SEL_JUMPR;
        else if (jump_abs) return SEL_JUMP;
        else if (br_taken) return SEL_BRANCH;
        else               return SEL_NONE;
    endfunction

endpackage

// File: rtl/fetch_target_gen.sv
// Redirect target generator: sign-extends the branch displacement, adds it, and muxes the target.
// Latency: purely combinational (0 cycles).
// Backpressure: none; the caller decides whether the redirect is accepted.
module fetch_target_gen
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter int TGT_W  = DEF_TGT_W
) (
    input  logic              ctl_valid,
    input  logic [ADDR_W-1:0] ctl_pc,
    input  logic              branch,
    input  logic              neg,
    input  logic              jump,
    input  logic              jumpR,
    input  logic [IMM_W-1:0]  imm16,
    input  logic [TGT_W-1:0]  tInstr,
    input  logic [ADDR_W-1:0] jumprAddr,
    output logic [ADDR_W-1:0] target,
    output logic              redir
);

    logic [ADDR_W-1:0] imm_sext;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jmp_target;
    tgt_sel_e          sel;

    assign imm_sext   = {{(ADDR_W-IMM_W){imm16[IMM_W-1]}}, imm16};
    assign br_target  = ctl_pc + imm_sext;
    assign jmp_target = {ctl_pc[ADDR_W-1:TGT_W], tInstr};
    assign sel        = sel_target(jumpR, jump, branch & neg);
    assign redir      = ctl_valid & (sel != SEL_NONE);

    // Pick the target of the highest-priority redirect source.
    always_comb begin
        target = br_target;
        case (sel)
            SEL_JUMPR:  target = jumprAddr;
            SEL_JUMP:   target = jmp_target;
            SEL_BRANCH: target = br_target;
            default:    target = br_target;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: holds the PC, drives instruction memory and presents PCs to decode.
// Latency: 1 cycle per handshake; redirect target on imem_addr next cycle, valid one cycle later.
// Backpressure: out_ready low holds the PC stable; redirect and halt override a stall.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                IMM_W    = DEF_IMM_W,
    parameter int                TGT_W    = DEF_TGT_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              out_ready,
    input  logic              ctl_valid,
    input  logic [ADDR_W-1:0] ctl_pc,
    input  logic              branch,
    input  logic              neg,
    input  logic              jump,
    input  logic              jumpR,
    input  logic [IMM_W-1:0]  imm16,
    input  logic [TGT_W-1:0]  tInstr,
    input  logic [ADDR_W-1:0] jumprAddr,
    input  logic              halt,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  redirect_cnt
);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] target;
    logic              redir;
    logic              active;
    logic              halt_req;
    logic              take_redir;

    fetch_target_gen #(
        .ADDR_W (ADDR_W),
        .IMM_W  (IMM_W),
        .TGT_W  (TGT_W)
    ) u_target_gen (
        .ctl_valid (ctl_valid),
        .ctl_pc    (ctl_pc),
        .branch    (branch),
        .neg       (neg),
        .jump      (jump),
        .jumpR     (jumpR),
        .imm16     (imm16),
        .tInstr    (tInstr),
        .jumprAddr (jumprAddr),
        .target    (target),
        .redir     (redir)
    );

    // Control is only acted on in RUN and BUBBLE; halt outranks a redirect.
    assign active     = (state == RUN) || (state == BUBBLE);
    assign halt_req   = ctl_valid & halt;
    assign take_redir = active & ~halt_req & redir;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: halt > redirect > normal flow; HALT is sticky.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = RUN;
            RUN,
            BUBBLE: begin
                if (halt_req)   state_nxt = HALT;
                else if (redir) state_nxt = BUBBLE;
                else            state_nxt = RUN;
            end
            HALT:       state_nxt = HALT;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output decode from state.
    always_comb begin
        out_valid = (state == RUN);
        halted    = (state == HALT);
    end

    // Next PC: redirect target, sequential advance on a RUN handshake, else hold.
    always_comb begin
        pc_nxt = pc;
        if (take_redir)
            pc_nxt = target;
        else if ((state == RUN) && !halt_req && out_ready)
            pc_nxt = pc + ADDR_W'(1);
    end

    // PC, flush pulse and saturating redirect counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            flush        <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            pc    <= pc_nxt;
            flush <= take_redir;
            if (take_redir && (redirect_cnt != {CNT_W{1'b1}}))
                redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
    end

    assign imem_addr = pc;
    assign out_pc    = pc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized control traffic.
// A behavioural model tracks the expected PC, validity, flush and redirect count each cycle.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_fetch_pc_unit;

    localparam int ADDR_W = 30;
    localparam int IMM_W  = 16;
    localparam int TGT_W  = 26;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              out_ready;
    logic              ctl_valid;
    logic [ADDR_W-1:0] ctl_pc;
    logic              branch, neg, jump, jumpR, halt;
    logic [IMM_W-1:0]  imm16;
    logic [TGT_W-1:0]  tInstr;
    logic [ADDR_W-1:0] jumprAddr;

    logic [ADDR_W-1:0] imem_addr, out_pc, imem_addr_s, out_pc_s;
    logic              out_valid, flush, halted, out_valid_s, flush_s, halted_s;
    logic [CNT_W-1:0]  redirect_cnt;
    logic [1:0]        redirect_cnt_s;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .TGT_W(TGT_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .out_ready(out_ready), .ctl_valid(ctl_valid), .ctl_pc(ctl_pc),
        .branch(branch), .neg(neg), .jump(jump), .jumpR(jumpR), .imm16(imm16), .tInstr(tInstr),
        .jumprAddr(jumprAddr), .halt(halt), .imem_addr(imem_addr), .out_valid(out_valid),
        .out_pc(out_pc), .flush(flush), .halted(halted), .redirect_cnt(redirect_cnt)
    );

    fetch_pc_unit #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .TGT_W(TGT_W), .RESET_PC('0), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .out_ready(out_ready), .ctl_valid(ctl_valid), .ctl_pc(ctl_pc),
        .branch(branch), .neg(neg), .jump(jump), .jumpR(jumpR), .imm16(imm16), .tInstr(tInstr),
        .jumprAddr(jumprAddr), .halt(halt), .imem_addr(imem_addr_s), .out_valid(out_valid_s),
        .out_pc(out_pc_s), .flush(flush_s), .halted(halted_s), .redirect_cnt(redirect_cnt_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_started, m_bubble, m_halted, m_flush;
    longint      m_pc;
    int          m_cnt;
    localparam longint PC_MOD = 64'd1 << ADDR_W;

    function automatic longint model_target();
        longint d;
        longint hi_mask;
        if (jumpR) return longint'(jumprAddr);
        if (jump) begin
            hi_mask = (PC_MOD - 1) - ((64'd1 << TGT_W) - 1);
            return (longint'(ctl_pc) & hi_mask) + longint'(tInstr);
        end
        d = imm16[IMM_W-1] ? longint'(imm16) - 65536 : longint'(imm16);
        return (longint'(ctl_pc) + d + PC_MOD) % PC_MOD;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_started = 0; m_bubble = 0; m_halted = 0; m_flush = 0; m_pc = 0; m_cnt = 0;
        end else if (!m_started) begin
            m_started = 1; m_flush = 0;
        end else if (m_halted) begin
            m_flush = 0;
        end else if (ctl_valid && halt) begin
            m_halted = 1; m_flush = 0;
        end else if (ctl_valid && (jumpR || jump || (branch && neg))) begin
            m_pc = model_target(); m_bubble = 1; m_flush = 1; m_cnt++;
        end else begin
            m_flush = 0;
            if (m_bubble) m_bubble = 0;
            else if (out_ready) m_pc = (m_pc + 1) % PC_MOD;
        end
    end

    // Compare every cycle against the model once a reset edge has been seen.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_addr", 64'(imem_addr), 64'(m_pc));
            chk("out_pc", 64'(out_pc), 64'(m_pc));
            chk("out_valid", 64'(out_valid), 64'(m_started && !m_bubble && !m_halted));
            chk("flush", 64'(flush), 64'(m_flush));
            chk("halted", 64'(halted), 64'(m_halted));
            chk("redirect_cnt", 64'(redirect_cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
            chk("small_pc", 64'(imem_addr_s), 64'(m_pc));
            chk("small_out_pc", 64'(out_pc_s), 64'(m_pc));
            chk("small_valid", 64'(out_valid_s), 64'(m_started && !m_bubble && !m_halted));
            chk("small_flush", 64'(flush_s), 64'(m_flush));
            chk("small_halted", 64'(halted_s), 64'(m_halted));
            chk("small_cnt", 64'(redirect_cnt_s), 64'((m_cnt > 3) ? 3 : m_cnt));
        end
    end

    task automatic ctl_clear();
        ctl_valid = 0; branch = 0; neg = 0; jump = 0; jumpR = 0; halt = 0;
        ctl_pc = '0; imm16 = '0; tInstr = '0; jumprAddr = '0;
    endtask

    initial begin
        reset = 1; out_ready = 0; ctl_clear();
        @(negedge clk); chk_en = 1;
        @(negedge clk);
        chk("rst_pc", 64'(imem_addr), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_cnt", 64'(redirect_cnt), 64'h0);
        chk("rst_flush", 64'(flush), 64'h0);
        reset = 0; out_ready = 1;

        // Sequential advance from RESET_PC.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq_pc", 64'(out_pc), 64'(i));
            chk("seq_valid", 64'(out_valid), 64'h1);
        end
        repeat (12) @(negedge clk);
        @(negedge clk);
        chk("pc_0x10", 64'(out_pc), 64'h10);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc", 64'(out_pc), 64'h10);
            chk("stall_valid", 64'(out_valid), 64'h1);
        end
        out_ready = 1;
        @(negedge clk);
        chk("after_stall", 64'(out_pc), 64'h11);

        // Taken branch backwards by 4 words.
        ctl_valid = 1; branch = 1; neg = 1; ctl_pc = 30'h20; imm16 = 16'hFFFC;
        @(negedge clk);
        chk("br_target", 64'(imem_addr), 64'h1C);
        chk("br_flush", 64'(flush), 64'h1);
        chk("br_valid", 64'(out_valid), 64'h0);
        chk("br_cnt", 64'(redirect_cnt), 64'h1);
        ctl_clear();
        @(negedge clk);
        chk("br_resume", 64'(out_valid), 64'h1);
        chk("br_flush_end", 64'(flush), 64'h0);
        ctl_valid = 1; branch = 1; neg = 0; ctl_pc = 30'h20; imm16 = 16'hFFFC; out_ready = 0;
        @(negedge clk);
        chk("nt_pc", 64'(out_pc), 64'h1C);
        chk("nt_cnt", 64'(redirect_cnt), 64'h1);

        // Priority: jumpR beats jump and taken branch, then back-to-back jump.
        jumpR = 1; jumprAddr = 30'h100; jump = 1; neg = 1;
        @(negedge clk);
        chk("prio_pc", 64'(imem_addr), 64'h100);
        ctl_clear();
        ctl_valid = 1; jump = 1; ctl_pc = 30'h3000_0000; tInstr = 26'h5;
        @(negedge clk);
        chk("jmp_pc", 64'(imem_addr), 64'h3000_0005);
        chk("jmp_flush", 64'(flush), 64'h1);
        chk("jmp_cnt", 64'(redirect_cnt), 64'h3);

        // PC wrap at all-ones.
        ctl_clear(); ctl_valid = 1; jumpR = 1; jumprAddr = 30'h3FFF_FFFF;
        @(negedge clk);
        ctl_clear(); out_ready = 1;
        @(negedge clk);
        chk("wrap_pre", 64'(out_pc), 64'h3FFF_FFFF);
        @(negedge clk);
        chk("wrap_pc", 64'(out_pc), 64'h0);

        // Fifth redirect, then halt together with a redirect.
        ctl_valid = 1; jumpR = 1; jumprAddr = 30'h40;
        @(negedge clk);
        chk("cnt5", 64'(redirect_cnt), 64'h5);
        chk("cnt_sat", 64'(redirect_cnt_s), 64'h3);
        halt = 1; jumprAddr = 30'h55;
        @(negedge clk);
        chk("halt_pc", 64'(imem_addr), 64'h40);
        chk("halt_flag", 64'(halted), 64'h1);
        halt = 0;
        repeat (3) @(negedge clk);
        chk("halt_sticky", 64'(halted), 64'h1);
        chk("halt_hold", 64'(imem_addr), 64'h40);
        reset = 1;
        @(negedge clk);
        chk("rst2_pc", 64'(imem_addr), 64'h0);
        chk("rst2_halted", 64'(halted), 64'h0);
        chk("rst2_cnt", 64'(redirect_cnt), 64'h0);
        reset = 0; ctl_clear();

        // Randomized traffic checked by the model each cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset     = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ctl_valid = ($urandom_range(0, 2) == 0);
            branch    = 1'($urandom);
            neg       = 1'($urandom);
            jump      = ($urandom_range(0, 5) == 0);
            jumpR     = ($urandom_range(0, 7) == 0);
            halt      = ($urandom_range(0, 150) == 0);
            ctl_pc    = ADDR_W'($urandom);
            imm16     = IMM_W'($urandom);
            tInstr    = TGT_W'($urandom);
            jumprAddr = ADDR_W'($urandom);
        end
        @(negedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
